// File: rtl/cbfp1_frame_ctrl_pkg.sv
// Shared types and constants for the CBFP1 frame controller.
// Imported by the interface, the min tree and the top.
package cbfp_ctrl_pkg;

    localparam int NCHAN           = 16;
    localparam int IDX_W           = 5;
    localparam int BEATS_PER_FRAME = 32;
    localparam int FRAME_CNT_W     = 16;
    localparam int MAX_OUTSTANDING = 8;
    localparam int BEAT_W          = $clog2(BEATS_PER_FRAME);
    localparam int OUT_W           = 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_FRAME - 1);

    typedef logic [IDX_W-1:0] idx_t;
    typedef idx_t [NCHAN-1:0] idx_vec_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

    function automatic idx_t min2(input idx_t a, input idx_t b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/cbfp1_frame_ctrl_if.sv
// Beat handshake between upstream butterfly, controller and CBFP1.
// master = environment side, slave = controller side.
interface cbfp1_frame_ctrl_if;
    import cbfp_ctrl_pkg::*;

    logic     up_valid;
    logic     up_ready;
    logic     cbfp_valid_in;
    logic     cbfp_valid_out;
    idx_vec_t cbfp_idx1;

    modport master (
        output up_valid,
        output cbfp_valid_out,
        output cbfp_idx1,
        input  up_ready,
        input  cbfp_valid_in
    );

    modport slave (
        input  up_valid,
        input  cbfp_valid_out,
        input  cbfp_idx1,
        output up_ready,
        output cbfp_valid_in
    );

endinterface

// File: rtl/cbfp1_frame_ctrl_idx_min_tree.sv
// Combinational minimum of the 16 idx1 lanes.
// Pairwise reduction 16 -> 8 -> 4 -> 2 -> 1.
module idx_min_tree
    import cbfp_ctrl_pkg::*;
(
    input  idx_vec_t lanes_i,
    output idx_t     min_o
);

    idx_t l1 [NCHAN/2];
    idx_t l2 [NCHAN/4];
    idx_t l3 [NCHAN/8];

    // four comparator levels
    always_comb begin
        for (int i = 0; i < NCHAN/2; i++) begin
            l1[i] = min2(lanes_i[2*i], lanes_i[2*i+1]);
        end
        for (int i = 0; i < NCHAN/4; i++) begin
            l2[i] = min2(l1[2*i], l1[2*i+1]);
        end
        for (int i = 0; i < NCHAN/8; i++) begin
            l3[i] = min2(l2[2*i], l2[2*i+1]);
        end
        min_o = min2(l3[0], l3[1]);
    end

endmodule

// File: rtl/cbfp1_frame_ctrl.sv
// CBFP1 frame sequencer: beat gating, frame tagging,
// per-frame minimum exponent and run start/done control.
module cbfp1_frame_ctrl
    import cbfp_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic [FRAME_CNT_W-1:0] frames_req_i,
    output logic                   busy_o,
    output logic                   done_o,
    cbfp1_frame_ctrl_if.slave      bus,
    output logic                   sof_out_o,
    output logic                   eof_out_o,
    output idx_t                   frame_min_idx_o,
    output logic                   frame_min_valid_o,
    output logic [FRAME_CNT_W-1:0] frames_done_o,
    output logic                   err_ovf_o
);

    ctrl_state_e state_q;

    logic up_ready_q, busy_q, done_q, stop_pend_q, err_q, fmv_q;

    logic [BEAT_W-1:0]      in_beat_q, in_beat_d;
    logic [BEAT_W-1:0]      out_beat_q, out_beat_d;
    logic [FRAME_CNT_W-1:0] in_frame_q, in_frame_d;
    logic [FRAME_CNT_W-1:0] frames_req_q;
    logic [FRAME_CNT_W-1:0] frames_done_q, frames_done_d;
    logic [OUT_W-1:0]       outst_q, outst_d;

    idx_t acc_q, acc_d, fmin_q, lane_min;

    logic acc_in, last_in, sof, eof, underflow, dec;
    logic fin_run, fin_drain;

    idx_min_tree u_min (
        .lanes_i (bus.cbfp_idx1),
        .min_o   (lane_min)
    );

    assign acc_in    = bus.up_valid & up_ready_q;
    assign last_in   = acc_in & (in_beat_q == LAST_BEAT);
    assign sof       = bus.cbfp_valid_out & (out_beat_q == '0);
    assign eof       = bus.cbfp_valid_out & (out_beat_q == LAST_BEAT);
    assign underflow = bus.cbfp_valid_out & (outst_q == '0);
    assign dec       = bus.cbfp_valid_out & ~underflow;

    assign bus.cbfp_valid_in = acc_in;
    assign bus.up_ready      = up_ready_q;

    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign sof_out_o         = sof;
    assign eof_out_o         = eof;
    assign frame_min_idx_o   = fmin_q;
    assign frame_min_valid_o = fmv_q;
    assign frames_done_o     = frames_done_q;
    assign err_ovf_o         = err_q;

    // next-state of counters, running minimum and end-of-run tests
    always_comb begin
        in_beat_d     = in_beat_q;
        in_frame_d    = in_frame_q;
        out_beat_d    = out_beat_q;
        acc_d         = acc_q;
        if (acc_in) begin
            in_beat_d = last_in ? '0 : in_beat_q + BEAT_W'(1);
            if (last_in) begin
                in_frame_d = in_frame_q + FRAME_CNT_W'(1);
            end
        end
        if (bus.cbfp_valid_out) begin
            out_beat_d = eof ? '0 : out_beat_q + BEAT_W'(1);
            acc_d      = sof ? lane_min : min2(acc_q, lane_min);
        end
        frames_done_d = frames_done_q + FRAME_CNT_W'(eof);
        outst_d       = outst_q + OUT_W'(acc_in) - OUT_W'(dec);
        fin_run       = last_in &
                        ((frames_req_q != '0)
                         ? (in_frame_q + FRAME_CNT_W'(1) == frames_req_q)
                         : (stop_pend_q | stop_i));
        fin_drain     = (frames_done_d == in_frame_q) & (outst_d == '0);
    end

    // run FSM with registered status outputs and counter state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            up_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            stop_pend_q   <= 1'b0;
            err_q         <= 1'b0;
            fmv_q         <= 1'b0;
            fmin_q        <= '1;
            acc_q         <= '1;
            in_beat_q     <= '0;
            in_frame_q    <= '0;
            out_beat_q    <= '0;
            frames_req_q  <= '0;
            frames_done_q <= '0;
            outst_q       <= '0;
        end else begin
            done_q        <= 1'b0;
            fmv_q         <= eof;
            acc_q         <= acc_d;
            in_beat_q     <= in_beat_d;
            in_frame_q    <= in_frame_d;
            out_beat_q    <= out_beat_d;
            frames_done_q <= frames_done_d;
            outst_q       <= outst_d;
            if (eof) begin
                fmin_q <= acc_d;
            end
            if (underflow || (outst_q > OUT_W'(MAX_OUTSTANDING))) begin
                err_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q       <= RUN;
                        up_ready_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        frames_req_q  <= frames_req_i;
                        stop_pend_q   <= 1'b0;
                        err_q         <= 1'b0;
                        in_beat_q     <= '0;
                        in_frame_q    <= '0;
                        out_beat_q    <= '0;
                        frames_done_q <= '0;
                        outst_q       <= '0;
                    end
                end
                RUN: begin
                    if (stop_i) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (fin_run) begin
                        state_q    <= DRAIN;
                        up_ready_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fin_drain) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    up_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbfp1_frame_ctrl.sv
// Self-checking bench for cbfp1_frame_ctrl with a latency-2
// CBFP1 stand-in and a frame-level reference model.
module tb_cbfp1_frame_ctrl;
    import cbfp_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] frames_req;
    logic        busy, done, sof, eof, fmv, err;
    logic [4:0]  fmin;
    logic [15:0] frames_done;

    int checks   = 0;
    int failures = 0;

    logic p1, p2;

    cbfp1_frame_ctrl_if bus ();

    always #5 clk = ~clk;

    cbfp1_frame_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start),
        .stop_i            (stop),
        .frames_req_i      (frames_req),
        .busy_o            (busy),
        .done_o            (done),
        .bus               (bus),
        .sof_out_o         (sof),
        .eof_out_o         (eof),
        .frame_min_idx_o   (fmin),
        .frame_min_valid_o (fmv),
        .frames_done_o     (frames_done),
        .err_ovf_o         (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_drive();
        start              = 1'b0;
        stop               = 1'b0;
        bus.up_valid       = 1'b0;
        bus.cbfp_valid_out = 1'b0;
    endtask

    // One run. mode 0: random idx1, mode 1: all 9 with lane5=3 on beat 17.
    // stop_at / rst_at: accepted-beat count at which to pulse stop / rst.
    task automatic run(input int nreq, input int exp_beats, input int pct,
                       input int mode, input int stop_at, input int rst_at);
        int       acc_n, out_n, last_acc, done_n;
        bit       fin, stop_sent, rst_sent, rst_chk, fmv_exp, vout;
        idx_t     run_min, fmin_want, lm;
        idx_vec_t iv;
        acc_n = 0; out_n = 0; last_acc = 0; done_n = 0;
        fin = 0; stop_sent = 0; rst_sent = 0; rst_chk = 0; fmv_exp = 0;
        run_min = '1; fmin_want = '1;
        p1 = 1'b0; p2 = 1'b0;
        for (int c = 0; c < 1500 && !fin; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            frames_req = 16'(nreq);
            vout       = p2;
            bus.up_valid = (c > 0) && ($urandom_range(99) < pct);
            stop = 1'b0;
            if (stop_at >= 0 && !stop_sent && acc_n == stop_at) begin
                stop = 1'b1; stop_sent = 1;
            end
            rst = 1'b0;
            if (rst_sent) begin
                rst_chk = 1;
            end else if (rst_at >= 0 && acc_n == rst_at) begin
                rst = 1'b1; rst_sent = 1;
            end
            for (int l = 0; l < NCHAN; l++) begin
                iv[l] = (mode == 1) ? idx_t'(9) : idx_t'($urandom_range(24));
            end
            if (mode == 1 && out_n % 32 == 17) iv[5] = idx_t'(3);
            bus.cbfp_valid_out = vout;
            bus.cbfp_idx1      = iv;
            @(negedge clk);
            if (rst_chk) begin
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ready", bus.up_ready, 0);
                chk("rst_vin", bus.cbfp_valid_in, 0);
                chk("rst_fmv", fmv, 0);
                chk("rst_fmin", fmin, 31);
                chk("rst_fdone", frames_done, 0);
                chk("rst_err", err, 0);
                fin = 1;
            end else begin
                if (bus.cbfp_valid_in) begin
                    acc_n++; last_acc = c;
                end
                p2 = p1; p1 = bus.cbfp_valid_in;
                if (rst_sent) begin p1 = 1'b0; p2 = 1'b0; end
                if (c >= 1) chk("err_clear", err, 0);
                chk("fmv", fmv, fmv_exp);
                if (fmv_exp) chk("fmin", fmin, fmin_want);
                fmv_exp = 0;
                if (vout) begin
                    lm = iv[0];
                    foreach (iv[l]) if (iv[l] < lm) lm = iv[l];
                    if (out_n % 32 == 0 || lm < run_min) run_min = lm;
                    chk("sof", sof, out_n % 32 == 0);
                    chk("eof", eof, out_n % 32 == 31);
                    if (out_n % 32 == 31) begin
                        fmv_exp = 1; fmin_want = run_min;
                    end
                    out_n++;
                end
                if (done) begin
                    done_n++;
                    chk("done_cycle", c, last_acc + 3);
                    chk("busy_at_done", busy, 0);
                    fin = 1;
                end
            end
        end
        chk("finished", fin, 1);
        idle_drive();
        rst = 1'b0;
        if (rst_at < 0) begin
            chk("in_beats", acc_n, exp_beats);
            chk("out_beats", out_n, exp_beats);
            chk("frames_done", frames_done, exp_beats / 32);
            chk("err_end", err, 0);
            repeat (3) begin
                @(negedge clk);
                chk("done_once", done, 0);
                chk("busy_low", busy, 0);
            end
        end else begin
            repeat (3) begin
                @(negedge clk);
                chk("no_done_after_rst", done, 0);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        frames_req = '0;
        bus.cbfp_idx1 = '0;
        idle_drive();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", bus.up_ready, 0);
        chk("reset_fmv", fmv, 0);
        chk("reset_sof", sof, 0);
        chk("reset_eof", eof, 0);
        chk("reset_err", err, 0);
        chk("reset_fmin", fmin, 31);
        chk("reset_fdone", frames_done, 0);

        // two fixed frames, no gaps
        run(2, 64, 100, 0, -1, -1);
        // single frame with directed minimum
        run(1, 32, 100, 1, -1, -1);
        // continuous mode stopped at frame 2 beat 10
        run(0, 96, 100, 0, 74, -1);
        // one frame with 50% upstream gaps
        run(1, 32, 50, 0, -1, -1);

        // stray output beat while idle
        @(posedge clk); #1 bus.cbfp_valid_out = 1'b1;
        @(posedge clk); #1 bus.cbfp_valid_out = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("idle_err", err, 1);
        end

        // reset mid-run at beat 20, then a clean run
        run(4, 0, 100, 0, -1, 20);
        run(1, 32, 100, 0, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
